// File: rtl/seq_pattern_decoder.sv
// Receive-side checker for the light-sequence generator: tracks which sequence
// runs on the active-low {CA,CB,CF,CG} lines, declares lock and counts illegal samples.
module seq_pattern_decoder #(
    parameter int unsigned LOCK_CYCLES = 2,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Tick,
    input  logic [3:0]       Seg,
    output logic [1:0]       Mode,
    output logic             Locked,
    output logic             Err,
    output logic [ERR_W-1:0] ErrCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRK_L = 2'b01,
        TRK_R = 2'b10,
        TRK_H = 2'b11
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_CYCLES);

    state_t     state, state_nx;
    logic [1:0] phase, phase_nx;
    logic [3:0] cnt, cnt_nx;
    logic [3:0] p;
    logic [1:0] last_ph, nxt_ph;
    logic [3:0] exp_pat;
    logic       reeval;
    logic       ev_close, ev_stop, ev_mismatch, ev_illegal;
    logic       err_nx, lock_nx;
    logic [1:0] mode_nx;

    assign p = ~Seg;

    function automatic logic [3:0] pattern(input state_t s, input logic [1:0] ph);
        logic [3:0] r;
        r = 4'b0000;
        case (s)
            TRK_L: case (ph)
                2'd1:    r = 4'b1000;
                2'd2:    r = 4'b1010;
                2'd3:    r = 4'b1011;
                default: r = 4'b0000;
            endcase
            TRK_R: case (ph)
                2'd1:    r = 4'b0100;
                2'd2:    r = 4'b0101;
                default: r = 4'b0000;
            endcase
            TRK_H:   r = (ph == 2'd1) ? 4'b1111 : 4'b0000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    always_comb begin
        case (state)
            TRK_L:   last_ph = 2'd3;
            TRK_R:   last_ph = 2'd2;
            TRK_H:   last_ph = 2'd1;
            default: last_ph = 2'd0;
        endcase
        nxt_ph  = (phase == last_ph) ? 2'd0 : phase + 2'd1;
        exp_pat = pattern(state, nxt_ph);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            phase    <= '0;
            cnt      <= '0;
            Mode     <= '0;
            Locked   <= 1'b0;
            Err      <= 1'b0;
            ErrCount <= '0;
        end else begin
            state  <= state_nx;
            phase  <= phase_nx;
            cnt    <= cnt_nx;
            Mode   <= mode_nx;
            Locked <= lock_nx;
            Err    <= err_nx;
            if (err_nx && (ErrCount != '1))
                ErrCount <= ErrCount + 1'b1;
        end
    end

    // A mismatching sample is re-run through the IDLE rules so a new start
    // pattern is acquired immediately and costs exactly one Err.
    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        cnt_nx      = cnt;
        reeval      = 1'b0;
        ev_close    = 1'b0;
        ev_stop     = 1'b0;
        ev_mismatch = 1'b0;
        ev_illegal  = 1'b0;
        if (Tick) begin
            if (state == IDLE) begin
                reeval = 1'b1;
            end else if (p == exp_pat) begin
                phase_nx = nxt_ph;
                if (nxt_ph == 2'd0) begin
                    ev_close = 1'b1;
                    if (cnt < LOCK_N)
                        cnt_nx = cnt + 4'd1;
                end
            end else if ((phase == 2'd0) && (p == 4'b0000)) begin
                ev_stop  = 1'b1;
                state_nx = IDLE;
                phase_nx = '0;
                cnt_nx   = '0;
            end else begin
                ev_mismatch = 1'b1;
                reeval      = 1'b1;
            end
            if (reeval) begin
                phase_nx = 2'd1;
                cnt_nx   = '0;
                case (p)
                    4'b1000: state_nx = TRK_L;
                    4'b0100: state_nx = TRK_R;
                    4'b1111: state_nx = TRK_H;
                    default: begin
                        state_nx   = IDLE;
                        phase_nx   = '0;
                        ev_illegal = (p != 4'b0000);
                    end
                endcase
            end
        end
    end

    always_comb begin
        err_nx  = ev_mismatch | ev_illegal;
        lock_nx = Locked;
        mode_nx = Mode;
        if (ev_stop || ev_mismatch) begin
            lock_nx = 1'b0;
            mode_nx = 2'b00;
        end else if (ev_close && (cnt_nx == LOCK_N)) begin
            lock_nx = 1'b1;
            mode_nx = state;
        end
    end

endmodule

// File: tb/tb_seq_pattern_decoder.sv
// Self-checking bench for seq_pattern_decoder: directed scenarios plus random
// sequences compared against a table-driven reference model.
module tb_seq_pattern_decoder;

    localparam int LOCK  = 2;
    localparam int EW    = 3;
    localparam int CMAX  = (1 << EW) - 1;

    logic          Clk;
    logic          Rst;
    logic          Tick;
    logic [3:0]    Seg;
    logic [1:0]    Mode;
    logic          Locked;
    logic          Err;
    logic [EW-1:0] ErrCount;

    int checks = 0;
    int errors = 0;

    seq_pattern_decoder #(.LOCK_CYCLES(LOCK), .ERR_W(EW)) dut (
        .Clk(Clk), .Rst(Rst), .Tick(Tick), .Seg(Seg),
        .Mode(Mode), .Locked(Locked), .Err(Err), .ErrCount(ErrCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: track 0 = none, 1 = left, 2 = right, 3 = hazard.
    int         per [4] = '{1, 4, 3, 2};
    logic [3:0] seqs [4][4] = '{'{4'h0, 4'h0, 4'h0, 4'h0},
                                '{4'h0, 4'h8, 4'hA, 4'hB},
                                '{4'h0, 4'h4, 4'h5, 4'h0},
                                '{4'h0, 4'hF, 4'h0, 4'h0}};
    int         m_track, m_phase, m_cycles, m_cnt;
    logic       m_locked, m_err;
    logic [1:0] m_mode;

    function automatic void model_reset();
        m_track = 0; m_phase = 0; m_cycles = 0; m_cnt = 0;
        m_locked = 1'b0; m_err = 1'b0; m_mode = 2'b00;
    endfunction

    function automatic void model_step(input logic [3:0] p);
        int n;
        bit found;
        m_err = 1'b0;
        if (m_track != 0) begin
            n = (m_phase + 1) % per[m_track];
            if (p == seqs[m_track][n]) begin
                m_phase = n;
                if (n == 0) begin
                    m_cycles = (m_cycles < LOCK) ? m_cycles + 1 : LOCK;
                    if (m_cycles == LOCK) begin
                        m_locked = 1'b1;
                        m_mode   = 2'(m_track);
                    end
                end
                return;
            end
            if (m_phase == 0 && p == 4'h0) begin
                model_reset_track();
                return;
            end
            m_err = 1'b1;
            model_reset_track();
        end
        found = 0;
        for (int t = 1; t < 4; t++)
            if (!found && p == seqs[t][1]) begin
                found = 1; m_track = t; m_phase = 1; m_cycles = 0;
            end
        if (!found) begin
            m_track = 0; m_phase = 0;
            if (p != 4'h0) m_err = 1'b1;
        end
        if (m_err && m_cnt < CMAX) m_cnt++;
    endfunction

    function automatic void model_reset_track();
        m_track = 0; m_phase = 0; m_cycles = 0;
        m_locked = 1'b0; m_mode = 2'b00;
    endfunction

    task automatic tick(input logic [3:0] p);
        @(negedge Clk);
        Seg  = ~p;
        Tick = 1'b1;
        model_step(p);
        @(negedge Clk);
        Tick = 1'b0;
        Seg  = 4'($urandom);
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            Seg  = 4'($urandom);
            Tick = 1'($urandom);
            checks++;
            if ({Mode, Locked, Err, ErrCount} !== '0) begin
                errors++;
                $display("FAIL reset_hold: mode=%b locked=%b err=%b cnt=%0d, required all zero",
                         Mode, Locked, Err, ErrCount);
            end
        end
        @(negedge Clk);
        Tick = 1'b0;
        Rst  = 1'b1;
        model_reset();
    endtask

    task automatic test_left_lock();
        logic [3:0] s [9] = '{4'h0, 4'h8, 4'hA, 4'hB, 4'h0, 4'h8, 4'hA, 4'hB, 4'h0};
        for (int i = 0; i < 9; i++) begin
            tick(s[i]);
            checks++;
            if (Err !== 1'b0 || Locked !== (i == 8) || Mode !== ((i == 8) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL left_lock[%0d]: mode=%b locked=%b err=%b, required mode=%b locked=%b err=0",
                         i, Mode, Locked, Err, (i == 8) ? 2'b01 : 2'b00, (i == 8));
            end
        end
        @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        checks++;
        if ({Mode, Locked, Err, ErrCount} !== '0) begin
            errors++;
            $display("FAIL async_reset: mode=%b locked=%b err=%b cnt=%0d, required all zero",
                     Mode, Locked, Err, ErrCount);
        end
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();
    endtask

    task automatic test_hazard_stop();
        logic [3:0] s [5] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0};
        for (int i = 0; i < 5; i++) begin
            tick(s[i]);
            checks++;
            if (Err !== 1'b0 || Locked !== (i == 3) || Mode !== ((i == 3) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL hazard_stop[%0d]: mode=%b locked=%b err=%b, required mode=%b locked=%b err=0",
                         i, Mode, Locked, Err, (i == 3) ? 2'b11 : 2'b00, (i == 3));
            end
        end
    endtask

    task automatic test_illegal_step();
        int pulses = 0;
        apply_reset();
        tick(4'h8); pulses += Err;
        tick(4'hA); pulses += Err;
        tick(4'h5); pulses += Err;
        checks++;
        if (pulses != 1 || ErrCount !== 3'd1) begin
            errors++;
            $display("FAIL illegal_step: pulses=%0d cnt=%0d, required pulses=1 cnt=1", pulses, ErrCount);
        end
        @(negedge Clk);
        checks++;
        if (Err !== 1'b0) begin
            errors++;
            $display("FAIL err_width: err=%b one cycle later, required 0", Err);
        end
        // From IDLE the right-start is accepted cleanly, then 0101 continues it.
        tick(4'h4);
        tick(4'h5);
        checks++;
        if (Err !== 1'b0 || ErrCount !== 3'd1) begin
            errors++;
            $display("FAIL enter_right: err=%b cnt=%0d, required err=0 cnt=1", Err, ErrCount);
        end
    endtask

    task automatic test_reacquire();
        logic [3:0] r [7] = '{4'h4, 4'h5, 4'h0, 4'h4, 4'h5, 4'h0, 4'h4};
        logic [3:0] l [7] = '{4'hA, 4'hB, 4'h0, 4'h8, 4'hA, 4'hB, 4'h0};
        apply_reset();
        foreach (r[i]) tick(r[i]);
        checks++;
        if (Locked !== 1'b1 || Mode !== 2'b10) begin
            errors++;
            $display("FAIL right_lock: mode=%b locked=%b, required mode=10 locked=1", Mode, Locked);
        end
        tick(4'h8);
        checks++;
        if (Err !== 1'b1 || Locked !== 1'b0 || Mode !== 2'b00 || ErrCount !== 3'd1) begin
            errors++;
            $display("FAIL reacq_err: err=%b locked=%b mode=%b cnt=%0d, required err=1 locked=0 mode=00 cnt=1",
                     Err, Locked, Mode, ErrCount);
        end
        foreach (l[i]) tick(l[i]);
        checks++;
        if (Locked !== 1'b1 || Mode !== 2'b01 || ErrCount !== 3'd1) begin
            errors++;
            $display("FAIL reacq_lock: mode=%b locked=%b cnt=%0d, required mode=01 locked=1 cnt=1",
                     Mode, Locked, ErrCount);
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            tick(4'h6);
            pulses += Err;
        end
        checks++;
        if (pulses != 10 || ErrCount !== 3'd7) begin
            errors++;
            $display("FAIL saturation: pulses=%0d cnt=%0d, required pulses=10 cnt=7", pulses, ErrCount);
        end
    endtask

    task automatic test_gating();
        logic [1:0] mode0;
        logic       lock0;
        logic [EW-1:0] cnt0;
        apply_reset();
        foreach (seqs[3][i]) if (i < 2) tick(seqs[3][i]);
        tick(4'hF); tick(4'h0); tick(4'hF); tick(4'h0);
        mode0 = Mode; lock0 = Locked; cnt0 = ErrCount;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            Seg = 4'($urandom);
            checks++;
            if (Mode !== mode0 || Locked !== lock0 || ErrCount !== cnt0 || Err !== 1'b0 ||
                Mode !== 2'b11 || Locked !== 1'b1) begin
                errors++;
                $display("FAIL gating[%0d]: mode=%b locked=%b err=%b cnt=%0d, required mode=11 locked=1 err=0 cnt=%0d",
                         i, Mode, Locked, Err, ErrCount, cnt0);
            end
        end
    endtask

    task automatic test_random();
        int s = 1, sp = 0, r;
        logic [3:0] p;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) apply_reset();
            r = $urandom_range(0, 99);
            if (r < 6) p = 4'($urandom);
            else if (r < 9) p = 4'h0;
            else begin
                if (sp == 0 && $urandom_range(0, 9) == 0) s = $urandom_range(1, 3);
                sp = (sp + 1) % per[s];
                p  = seqs[s][sp];
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge Clk);
                Seg = 4'($urandom);
            end
            tick(p);
            checks++;
            if ({Mode, Locked, Err, ErrCount} !== {m_mode, m_locked, m_err, EW'(m_cnt)}) begin
                errors++;
                $display("FAIL random[%0d] p=%h: mode=%b locked=%b err=%b cnt=%0d, required mode=%b locked=%b err=%b cnt=%0d",
                         i, p, Mode, Locked, Err, ErrCount, m_mode, m_locked, m_err, m_cnt);
            end
        end
    endtask

    initial begin
        Rst  = 1'b0;
        Tick = 1'b0;
        Seg  = '1;
        model_reset();
        test_reset();
        test_left_lock();
        test_hazard_stop();
        test_illegal_step();
        test_reacquire();
        test_saturation();
        test_gating();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
